// File: rtl/tt_um_seg_decoder.sv
// rtl/tt_um_seg_decoder.sv - 7-segment pattern receiver: sync, debounce, decode, commit counter
module tt_um_seg_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [7:0]       s1, s2;
  logic [6:0]       cand, committed;
  logic             has_committed;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       digit;
  logic             valid, error, blank, new_pulse;
  logic [7:0]       count;

  logic             changed, stable, freeze, commit;
  logic [3:0]       dec_digit;
  logic             dec_valid, dec_error, dec_blank;

  logic             unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

  assign freeze  = s2[7];
  assign changed = (s2[6:0] != cand);
  assign stable  = !changed && (cnt == CNT_MAX);
  // The very first stable pattern after reset always commits, even one equal to the reset value.
  assign commit  = stable && !freeze && (!has_committed || (cand != committed));

  always_comb begin
    state_next = state;
    if (changed) begin
      state_next = SETTLE;
    end else if (commit) begin
      state_next = LOCKED;
    end else if (stable && has_committed && (cand == committed)) begin
      state_next = LOCKED;
    end
  end

  always_comb begin
    dec_digit = 4'hF;
    dec_valid = 1'b1;
    dec_error = 1'b0;
    dec_blank = 1'b0;
    case (cand)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_valid = 1'b0;
        dec_error = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s1            <= 8'h00;
      s2            <= 8'h00;
      cand          <= 7'h00;
      cnt           <= '0;
      committed     <= 7'h00;
      has_committed <= 1'b0;
      digit         <= 4'h0;
      valid         <= 1'b0;
      error         <= 1'b0;
      blank         <= 1'b0;
      new_pulse     <= 1'b0;
      count         <= 8'h00;
    end else begin
      state     <= state_next;
      s1        <= ui_in;
      s2        <= s1;
      new_pulse <= commit;
      if (changed) begin
        cand <= s2[6:0];
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (commit) begin
        committed     <= cand;
        has_committed <= 1'b1;
        digit         <= dec_digit;
        valid         <= dec_valid;
        error         <= dec_error;
        blank         <= dec_blank;
        count         <= count + 8'd1;
      end
    end
  end

  assign uo_out  = {blank, new_pulse, error, valid, digit};
  assign uio_out = count;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_seg_decoder.sv
// tb/tb_tt_um_seg_decoder.sv - directed self-checking bench for tt_um_seg_decoder
module tb_tt_um_seg_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;
  int seen_new;
  logic found;

  tt_um_seg_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_new(input int max, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (uo_out[6] === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    ui_in = 8'h06;
    #12;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;

    // 1: 06 held from edge 1 commits on edge 7
    seen_new = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (uo_out[6]) seen_new++;
    end
    chk("t1_no_early_new", 8'(seen_new), 8'd0);
    tick();
    chk("t1_edge7_uo", uo_out, 8'h51);
    chk("t1_edge7_cnt", uio_out, 8'h01);
    tick();
    chk("t1_pulse_end", uo_out, 8'h11);

    // 2: short glitch to 4F then back to 06
    ui_in = 8'h4F;
    tick(); tick();
    ui_in = 8'h06;
    seen_new = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (uo_out[6]) seen_new++;
    end
    chk("t2_no_new", 8'(seen_new), 8'd0);
    chk("t2_uo", uo_out, 8'h11);
    chk("t2_cnt", uio_out, 8'h01);

    // 3: digit 2 then illegal 49
    ui_in = 8'h5B;
    wait_new(12, found);
    chk("t3_5b_timeout", {7'd0, found}, 8'd1);
    chk("t3_5b_uo", uo_out, 8'h52);
    ui_in = 8'h49;
    wait_new(12, found);
    chk("t3_49_timeout", {7'd0, found}, 8'd1);
    chk("t3_49_uo", uo_out, 8'h6F);
    chk("t3_49_cnt", uio_out, 8'h03);

    // 4: freeze holds outputs while tracking continues
    ui_in = 8'h3F;
    wait_new(12, found);
    chk("t4_3f_timeout", {7'd0, found}, 8'd1);
    chk("t4_3f_uo", uo_out, 8'h50);
    ui_in = 8'hBF;
    tick(); tick(); tick();
    ui_in = 8'hFF;
    seen_new = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uo_out[6]) seen_new++;
    end
    chk("t4_frozen_no_new", 8'(seen_new), 8'd0);
    chk("t4_frozen_uo", uo_out, 8'h10);
    chk("t4_frozen_cnt", uio_out, 8'h04);
    ui_in = 8'h7F;
    wait_new(3, found);
    chk("t4_unfreeze_timeout", {7'd0, found}, 8'd1);
    chk("t4_unfreeze_uo", uo_out, 8'h58);
    chk("t4_unfreeze_cnt", uio_out, 8'h05);
    tick();
    chk("t4_single_pulse", uo_out, 8'h18);

    // 5: 256 alternating commits, counter wraps through 00
    seen_new = 0;
    for (int i = 0; i < 256; i++) begin
      ui_in = (i % 2 == 0) ? 8'h06 : 8'h3F;
      wait_new(12, found);
      if (!found) seen_new++;
      if (i == 250) chk("t5_wrap_zero", uio_out, 8'h00);
    end
    chk("t5_timeouts", 8'(seen_new), 8'd0);
    chk("t5_cnt_after_256", uio_out, 8'h05);
    chk("t5_last_uo", uo_out, 8'h50);
    ui_in = 8'h00;
    wait_new(12, found);
    chk("t5_blank_timeout", {7'd0, found}, 8'd1);
    chk("t5_blank_uo", uo_out, 8'hCF);
    tick();
    chk("t5_blank_hold", uo_out, 8'h8F);

    // 6: reset mid-settle clears outputs immediately
    ui_in = 8'h06;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_uo", uo_out, 8'h00);
    chk("t6_reset_cnt", uio_out, 8'h00);
    ui_in = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    wait_new(12, found);
    chk("t6_blank_timeout", {7'd0, found}, 8'd1);
    chk("t6_blank_uo", uo_out, 8'hCF);
    chk("t6_blank_cnt", uio_out, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
